// File: rtl/dmem_lsu.sv
// dmem_lsu: RV32I load/store unit driving a synchronous-read DMEM, with read-modify-write for SB/SH.
// Define LSU_ALIGN_CHECK_EN to flag misaligned halfword/word accesses as errors.
module dmem_lsu #(
    parameter int SIZE = 32,
    parameter int MEM_DEPTH = 1024,
    localparam int AW = $clog2(MEM_DEPTH)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [SIZE-1:0] req_addr,
    input  logic [SIZE-1:0] req_wdata,
    output logic            resp_valid,
    output logic [SIZE-1:0] resp_rdata,
    output logic            resp_err,
    output logic            mem_wren,
    output logic [AW-1:0]   mem_address,
    output logic [SIZE-1:0] mem_data_in,
    input  logic [SIZE-1:0] mem_data_out
);
    typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RESP} state_t;
    state_t state, state_nxt;
    logic is_b, is_h, is_w, mis;
    logic we_r, b_r, h_r, u_r, err_r;
    logic [1:0] off_r;
    logic [4:0] sh;
    logic [SIZE-1:0] lane_mask, shifted, lane, merged;
    logic unused_addr;
    assign is_b = req_funct3[1:0] == 2'b00;
    assign is_h = req_funct3[1:0] == 2'b01;
    assign is_w = req_funct3[1];
`ifdef LSU_ALIGN_CHECK_EN
    assign mis = (is_h & req_addr[0]) | (is_w & |req_addr[1:0]);
`else
    assign mis = 1'b0;
`endif
    assign unused_addr = ^req_addr[SIZE-1:AW+2];
    // Halfwords select their lane by addr[1] only, so addr[0] never shifts them.
    assign sh        = b_r ? {off_r, 3'b000} : {off_r[1], 4'b0000};
    assign lane_mask = (b_r ? SIZE'(8'hFF) : SIZE'(16'hFFFF)) << sh;
    assign shifted   = mem_data_out >> sh;
    assign lane      = b_r ? (u_r ? {{(SIZE-8){1'b0}}, shifted[7:0]} : {{(SIZE-8){shifted[7]}}, shifted[7:0]})
                     : h_r ? (u_r ? {{(SIZE-16){1'b0}}, shifted[15:0]} : {{(SIZE-16){shifted[15]}}, shifted[15:0]})
                     : mem_data_out;
    assign merged    = (mem_data_out & ~lane_mask) | ((mem_data_in << sh) & lane_mask);
    assign req_ready  = state == IDLE;
    assign resp_valid = (state == RESP) & ~reset;
    assign resp_err   = resp_valid & err_r;
    assign mem_wren   = (state == WR) & ~reset;
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = mis ? RESP : (req_we & is_w) ? WR : RD;
            RD:      state_nxt = WAIT;
            WAIT:    state_nxt = we_r ? WR : RESP;
            WR:      state_nxt = RESP;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            we_r        <= 1'b0;
            b_r         <= 1'b0;
            h_r         <= 1'b0;
            u_r         <= 1'b0;
            err_r       <= 1'b0;
            off_r       <= 2'b00;
            mem_address <= '0;
            mem_data_in <= '0;
            resp_rdata  <= '0;
        end else if (state == IDLE && req_valid) begin
            we_r        <= req_we;
            b_r         <= is_b;
            h_r         <= is_h;
            u_r         <= req_funct3[2];
            err_r       <= mis;
            off_r       <= req_addr[1:0];
            mem_address <= req_addr[AW+1:2];
            mem_data_in <= req_wdata;
            resp_rdata  <= '0;
        end else if (state == WAIT) begin
            if (we_r) mem_data_in <= merged;
            else resp_rdata <= lane;
        end
    end
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed self-checking bench for dmem_lsu with a behavioural synchronous-read DMEM.
module tb_dmem_lsu;
    logic        clock = 0, reset = 1, req_valid = 0, req_we = 0;
    logic [2:0]  req_funct3 = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic        req_ready, resp_valid, resp_err, mem_wren;
    logic [31:0] resp_rdata, mem_data_in, mem_rd;
    logic [9:0]  mem_address;
    logic        pre_en = 0;
    logic [9:0]  pre_addr = 0;
    logic [31:0] pre_data = 0;
    logic [31:0] mem [1024];
    int wr_cnt = 0, rv_cnt = 0, total = 0, bad = 0;
    logic [9:0] wr_addr = 0;
    int got_lat;
    logic [31:0] got_rdata;
    logic got_err;

    dmem_lsu dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_wren(mem_wren), .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_data_out(mem_rd)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        else if (mem_wren) begin
            mem[mem_address] <= mem_data_in;
            wr_cnt <= wr_cnt + 1;
            wr_addr <= mem_address;
        end
        if (resp_valid) rv_cnt <= rv_cnt + 1;
        mem_rd <= mem[mem_address];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        pre_en = 1; pre_addr = a; pre_data = d;
        @(posedge clock); #1;
        pre_en = 0;
    endtask

    task automatic txn(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input int exp_lat, input logic [31:0] exp_rdata,
                       input logic exp_err, input int exp_wr);
        int base;
        base = wr_cnt;
        req_valid = 1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
        @(posedge clock); #1;
        req_valid = 0;
        got_lat = 99; got_rdata = 'x; got_err = 'x;
        for (int e = 1; e <= 8; e++) begin
            if (resp_valid) begin
                got_lat = e; got_rdata = resp_rdata; got_err = resp_err;
                break;
            end
            @(posedge clock); #1;
        end
        chk({tag, " latency"}, 32'(got_lat), 32'(exp_lat));
        chk({tag, " rdata"}, got_rdata, exp_rdata);
        chk({tag, " err"}, {31'b0, got_err}, {31'b0, exp_err});
        chk({tag, " writes"}, 32'(wr_cnt - base), 32'(exp_wr));
        @(posedge clock); #1;
        chk({tag, " gap"}, {30'b0, resp_valid, req_ready}, 32'b01);
    endtask

    initial begin
        int rv_base, wr_base;
        repeat (2) @(posedge clock);
        #1;
        chk("rst outputs", {26'b0, resp_valid, resp_err, mem_wren, |resp_rdata, |mem_address, |mem_data_in}, 32'b0);
        reset = 0;
        chk("rst ready", {31'b0, req_ready}, 32'b1);
        preload(10'd4, 32'h11223344);
        preload(10'd26, 32'h8000FF7F);
        preload(10'd5, 32'hAAAAAAAA);

        txn("sw 0d4", 1, 3'b010, 32'h0D4, 32'h35, 2, 32'h0, 0, 1);
        chk("sw 0d4 addr", {22'b0, wr_addr}, 32'd53);
        chk("sw 0d4 mem", mem[53], 32'h35);
        txn("lw 0d4", 0, 3'b010, 32'h0D4, 32'h0, 3, 32'h35, 0, 0);

        txn("sb 012", 1, 3'b000, 32'h012, 32'hAB, 4, 32'h0, 0, 1);
        chk("sb 012 mem", mem[4], 32'h11AB3344);
        txn("sh 016", 1, 3'b001, 32'h016, 32'hFFFF1234, 4, 32'h0, 0, 1);
        chk("sh 016 mem", mem[5], 32'h1234AAAA);

        txn("lb 068", 0, 3'b000, 32'h068, 32'h0, 3, 32'h0000007F, 0, 0);
        txn("lb 069", 0, 3'b000, 32'h069, 32'h0, 3, 32'hFFFFFFFF, 0, 0);
        txn("lbu 069", 0, 3'b100, 32'h069, 32'h0, 3, 32'h000000FF, 0, 0);
        txn("lh 06a", 0, 3'b001, 32'h06A, 32'h0, 3, 32'hFFFF8000, 0, 0);
        txn("lhu 06a", 0, 3'b101, 32'h06A, 32'h0, 3, 32'h00008000, 0, 0);
        txn("f3 011 as lw", 0, 3'b011, 32'h068, 32'h0, 3, 32'h8000FF7F, 0, 0);

`ifdef LSU_ALIGN_CHECK_EN
        txn("lw 0d6 mis", 0, 3'b010, 32'h0D6, 32'h0, 1, 32'h0, 1, 0);
        txn("lh 069 mis", 0, 3'b001, 32'h069, 32'h0, 1, 32'h0, 1, 0);
        txn("sw 0d5 mis", 1, 3'b010, 32'h0D5, 32'h77, 1, 32'h0, 1, 0);
        chk("sw mis mem", mem[53], 32'h35);
`else
        txn("lw 0d6", 0, 3'b010, 32'h0D6, 32'h0, 3, 32'h35, 0, 0);
        txn("lh 069", 0, 3'b001, 32'h069, 32'h0, 3, 32'hFFFFFF7F, 0, 0);
`endif

        txn("sw wrap", 1, 3'b010, 32'h10000008, 32'hDEADBEEF, 2, 32'h0, 0, 1);
        chk("sw wrap addr", {22'b0, wr_addr}, 32'd2);
        chk("sw wrap mem", mem[2], 32'hDEADBEEF);

        rv_base = rv_cnt; wr_base = wr_cnt;
        req_valid = 1; req_we = 1; req_funct3 = 3'b001; req_addr = 32'h010; req_wdata = 32'h5555;
        @(posedge clock); #1;
        req_valid = 0;
        @(posedge clock); #1;
        reset = 1;
        @(posedge clock); #1;
        reset = 0;
        chk("abort ready", {31'b0, req_ready}, 32'b1);
        repeat (5) @(posedge clock);
        #1;
        chk("abort no resp", 32'(rv_cnt - rv_base), 32'd0);
        chk("abort no write", 32'(wr_cnt - wr_base), 32'd0);
        chk("abort mem", mem[4], 32'h11AB3344);
        txn("lw after abort", 0, 3'b010, 32'h010, 32'h0, 3, 32'h11AB3344, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/dmem_lsu.md
DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 SIZE, 32, data word width in bits.
REQ-002 MEM_DEPTH, 1024, DMEM depth in words; mem_address width is $clog2(MEM_DEPTH).
REQ-003 clock  input  1  single clock, rising-edge active.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  core access request.
REQ-006 req_ready  output  1  LSU idle and able to accept a request.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 req_addr  input  SIZE  byte address.
REQ-010 req_wdata  input  SIZE  store data, right-aligned.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  SIZE  load result, extended to SIZE bits.
REQ-013 resp_err  output  1  misaligned access, qualified by resp_valid.
REQ-014 mem_wren  output  1  DMEM write enable.
REQ-015 mem_address  output  $clog2(MEM_DEPTH)  DMEM word address, equal to req_addr[11:2] as latched.
REQ-016 mem_data_in  output  SIZE  DMEM write data.
REQ-017 mem_data_out  input  SIZE  DMEM read data, valid one cycle after the address is presented (synchronous read).

Function
REQ-018 The FSM SHALL have the states IDLE, RD, WAIT, WR and RESP; req_ready SHALL be 1 only in IDLE.
REQ-019 In IDLE, when req_valid is 1 at a rising edge, the LSU SHALL latch the request; otherwise it SHALL stay in IDLE.
- Misaligned request -> RESP.
- SW -> WR.
- Any load, SB or SH -> RD.
REQ-020 In RD, the LSU SHALL drive mem_address with mem_wren=0 and go to WAIT.
REQ-021 In WAIT, the LSU SHALL sample mem_data_out.
- Load: latch the extracted lane into resp_rdata, then go to RESP.
- SB/SH: latch the merged word (new lane replacing the old bytes, other bytes unchanged), then go to WR.
REQ-022 In WR, the LSU SHALL drive mem_wren=1 for exactly one cycle, with mem_data_in set to the SW data or the merged word, then go to RESP.
REQ-023 In RESP, resp_valid SHALL be 1 for exactly one cycle, then the FSM SHALL go to IDLE; back-to-back requests therefore have a minimum gap of one IDLE cycle.
REQ-024 Latency, counted in edges from the accepting edge to RESP entry:
- LW/LH/LB/LHU/LBU: 3.
- SW: 2.
- SB/SH: 4.
- misaligned: 1.
REQ-025 Lane select SHALL use addr[1:0] for bytes and addr[1] for halfwords.
- LB/LH: sign-extend.
- LBU/LHU: zero-extend.
REQ-026 resp_rdata SHALL be 0 for stores and for errored accesses; resp_err SHALL be 0 except on an errored RESP.
REQ-027 mem_wren SHALL be 1 only in WR while reset=0; no DMEM write occurs on any other cycle.
REQ-028 req_addr bits above bit 11 SHALL be ignored, so word addresses wrap modulo MEM_DEPTH.
REQ-029 An undefined funct3 (011, 110, 111) SHALL be treated as W width.

Reset
REQ-030 When reset=1 at a rising edge, the FSM SHALL go to IDLE and all of these SHALL be 0: resp_valid, resp_err, resp_rdata, mem_wren, mem_address, mem_data_in.
REQ-031 Reset mid-operation SHALL abandon the access.
- No DMEM write occurs, including during a pending SB/SH read-modify-write.
- No resp_valid is issued for the abandoned request.
REQ-032 req_ready SHALL be 1 on the first cycle after reset deasserts.

Configuration
REQ-033 With LSU_ALIGN_CHECK_EN defined, the following SHALL return resp_err=1 with no DMEM access:
- halfword access with addr[0]=1;
- word access with addr[1:0]!=0.
REQ-034 Without LSU_ALIGN_CHECK_EN, no access SHALL be flagged misaligned and resp_err SHALL be tied to 0.
- Word accesses ignore addr[1:0].
- Halfword accesses ignore addr[0].

Verification
REQ-035 SW addr=0x0D4, wdata=0x00000035 -> one mem_wren pulse at mem_address=53; resp_valid on the 2nd edge; then LW 0x0D4 returns resp_rdata=0x00000035 on the 3rd edge.
REQ-036 Word 0x11223344 preloaded at word 4, then SB addr=0x012, wdata=0xAB -> DMEM word 4 becomes 0x11AB3344 after exactly one write; resp_valid on the 4th edge.
REQ-037 Word 0x8000FF7F preloaded at word 26:
- LB addr=0x068 -> 0x0000007F;
- LB addr=0x069 -> 0xFFFFFFFF;
- LBU addr=0x069 -> 0x000000FF;
- LH addr=0x06A -> 0xFFFF8000;
- LHU addr=0x06A -> 0x00008000.
REQ-038 With LSU_ALIGN_CHECK_EN, LW addr=0x0D6 -> resp_valid and resp_err=1 on the 1st edge, no mem_wren, resp_rdata=0; without the macro, the same request returns the word at address 53.
REQ-039 Reset asserted for one cycle while in WAIT of SH addr=0x010 -> no mem_wren, no resp_valid, word 4 unchanged, req_ready=1 on the next cycle.
REQ-040 SW addr=0x1000_0008 -> writes mem_address=2 (upper bits ignored).
